// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the LSU (LSU priority, starvation guard).
// Latency: grant same cycle as request in IDLE; read response 3 cycles later, write ack 2 cycles later.
// Backpressure: mem_ready stalls ISSUE and mem_rvalid stalls WAIT_R indefinitely; no new grant until back in IDLE.
module mem_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_strb,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_strb,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    starve_cnt;
    logic                owner_ls;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [STRB_W-1:0]   lat_strb;
    logic [DATA_W-1:0]   rdata_q;
    logic                fetch_forced;

    // Fetch overrides the LSU only once it has lost STARVE_LIMIT times in a row.
    assign fetch_forced = if_req && (starve_cnt == LIMIT);

    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        ls_gnt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (ls_req && !fetch_forced) begin
                        ls_gnt  = 1'b1;
                        state_d = ISSUE;
                    end else if (if_req) begin
                        if_gnt  = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_d = lat_we ? RESP : WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_cnt <= '0;
            owner_ls   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_strb   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE) begin
                if (!if_req || if_gnt) begin
                    starve_cnt <= '0;
                end else if (ls_gnt && starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end

            // rdata_q is cleared at grant time so write acks return zero data.
            if (ls_gnt) begin
                owner_ls  <= 1'b1;
                lat_we    <= ls_we;
                lat_addr  <= ls_addr;
                lat_wdata <= ls_we ? ls_wdata : '0;
                lat_strb  <= ls_we ? ls_strb : '0;
                rdata_q   <= '0;
            end else if (if_gnt) begin
                owner_ls  <= 1'b0;
                lat_we    <= 1'b0;
                lat_addr  <= if_addr;
                lat_wdata <= '0;
                lat_strb  <= '0;
                rdata_q   <= '0;
            end

            if (state_q == WAIT_R && mem_rvalid) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_strb  = lat_strb;

    assign ls_rvalid = (state_q == RESP) && owner_ls;
    assign if_rvalid = (state_q == RESP) && !owner_ls;
    assign ls_rdata  = ls_rvalid ? rdata_q : '0;
    assign if_rdata  = if_rvalid ? rdata_q : '0;

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_strb;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_strb(ls_strb), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked at the falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic        exp_ls [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  exp_cnt[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

        rst = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0;
        ls_addr = 0; ls_wdata = 0; ls_strb = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        next(); next();
        rst = 1'b0;

        // Reset state
        at_neg();
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_gnts", {if_gnt, ls_gnt}, 0);
        chk("rst_rvalids", {if_rvalid, ls_rvalid}, 0);
        chk("rst_starve", dut.starve_cnt, 0);

        // LSU read alone
        next();
        ls_req = 1; ls_we = 0; ls_addr = 32'h100; ls_strb = 4'hF;
        at_neg();
        chk("rd_ls_gnt", ls_gnt, 1);
        chk("rd_if_gnt", if_gnt, 0);
        next();
        ls_req = 0; mem_ready = 1;
        at_neg();
        chk("rd_mem_req", mem_req, 1);
        chk("rd_mem_addr", mem_addr, 32'h100);
        chk("rd_mem_we_strb", {mem_we, mem_strb}, 0);
        next();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        at_neg();
        chk("rd_wait_noreq", mem_req, 0);
        chk("rd_wait_norv", ls_rvalid, 0);
        next();
        mem_rvalid = 0; mem_rdata = 0;
        at_neg();
        chk("rd_ls_rvalid", ls_rvalid, 1);
        chk("rd_ls_rdata", ls_rdata, 32'hDEADBEEF);
        chk("rd_if_rvalid", if_rvalid, 0);
        next();
        at_neg();
        chk("rd_done", {busy, ls_rvalid}, 0);

        // LSU write with three stall cycles
        next();
        ls_req = 1; ls_we = 1; ls_addr = 32'h204; ls_wdata = 32'h12345678; ls_strb = 4'b0100;
        at_neg();
        chk("wr_ls_gnt", ls_gnt, 1);
        for (int i = 0; i < 4; i++) begin
            next();
            ls_req = 0;
            mem_ready = (i == 3);
            at_neg();
            chk("wr_mem_req", mem_req, 1);
            chk("wr_mem_addr", mem_addr, 32'h204);
            chk("wr_mem_strb", mem_strb, 4'b0100);
            chk("wr_mem_wdata", {mem_we, mem_wdata}, {1'b1, 32'h12345678});
        end
        next();
        mem_ready = 0;
        at_neg();
        chk("wr_ls_rvalid", ls_rvalid, 1);
        chk("wr_ls_rdata", ls_rdata, 0);
        chk("wr_if_rvalid", if_rvalid, 0);
        next();

        // Simultaneous requests: LSU first, fetch right after
        ls_req = 1; ls_we = 0; ls_addr = 32'h300;
        if_req = 1; if_addr = 32'h40;
        at_neg();
        chk("sim_ls_gnt", {if_gnt, ls_gnt}, 2'b01);
        next();
        ls_req = 0; mem_ready = 1;
        at_neg();
        chk("sim_ls_addr", mem_addr, 32'h300);
        chk("sim_no_gnt", {if_gnt, ls_gnt}, 0);
        next();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
        next();
        mem_rvalid = 0;
        at_neg();
        chk("sim_ls_rvalid", {if_rvalid, ls_rvalid}, 2'b01);
        chk("sim_ls_rdata", ls_rdata, 32'hAAAA5555);
        chk("sim_resp_no_gnt", if_gnt, 0);
        next();
        at_neg();
        chk("sim_if_gnt", {if_gnt, ls_gnt}, 2'b10);
        next();
        if_req = 0; mem_ready = 1;
        at_neg();
        chk("sim_if_addr", mem_addr, 32'h40);
        chk("sim_if_we_strb", {mem_we, mem_strb}, 0);
        next();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00000013;
        next();
        mem_rvalid = 0;
        at_neg();
        chk("sim_if_rvalid", {if_rvalid, ls_rvalid}, 2'b10);
        chk("sim_if_rdata", if_rdata, 32'h00000013);
        next();

        // Both held continuously: starvation guard lets fetch in after four LSU grants
        if_req = 1; if_addr = 32'h80;
        ls_req = 1; ls_we = 1; ls_addr = 32'h400; ls_wdata = 32'h0BADF00D; ls_strb = 4'hF;
        for (int k = 0; k < 6; k++) begin
            at_neg();
            chk("stv_cnt", dut.starve_cnt, exp_cnt[k]);
            chk("stv_gnt", {if_gnt, ls_gnt}, exp_ls[k] ? 2'b01 : 2'b10);
            next();
            mem_ready = 1;
            at_neg();
            if (!exp_ls[k]) chk("stv_cnt_clr", dut.starve_cnt, 0);
            next();
            mem_ready = 0;
            if (!exp_ls[k]) begin
                mem_rvalid = 1; mem_rdata = 32'h13;
                next();
                mem_rvalid = 0;
            end
            at_neg();
            chk("stv_rvalid", {if_rvalid, ls_rvalid}, exp_ls[k] ? 2'b01 : 2'b10);
            next();
        end
        if_req = 0; ls_req = 0;
        next();

        // Reset while waiting for read data
        ls_req = 1; ls_we = 0; ls_addr = 32'h80;
        at_neg();
        chk("rw_ls_gnt", ls_gnt, 1);
        next();
        ls_req = 0; mem_ready = 1;
        next();
        mem_ready = 0; rst = 1;
        next();
        rst = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        at_neg();
        chk("rw_idle", {busy, mem_req, if_rvalid, ls_rvalid, if_gnt, ls_gnt}, 0);
        chk("rw_mem_addr", mem_addr, 0);
        chk("rw_rdata", {if_rdata, ls_rdata}, 0);
        next();
        mem_rvalid = 0;
        at_neg();
        chk("rw_no_rvalid", {busy, if_rvalid, ls_rvalid}, 0);
        next();
        if_req = 1; if_addr = 32'h44;
        at_neg();
        chk("rw_if_gnt", if_gnt, 1);
        next();
        if_req = 0; mem_ready = 1;
        at_neg();
        chk("rw_if_addr", mem_addr, 32'h44);
        next();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h55;
        next();
        mem_rvalid = 0;
        at_neg();
        chk("rw_if_rvalid", if_rvalid, 1);
        chk("rw_if_rdata", if_rdata, 32'h55);
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
